// File: rtl/usb_buf_arb.sv
// rtl/usb_buf_arb.sv - USB-write / AXI-read arbiter for a single-port word buffer.
// Define USB_BUF_ARB_WR_PRIO_EN for fixed write priority instead of round-robin.
module usb_buf_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              usb_wr_req,
  input  logic [DATA_W-1:0] usb_wr_data,
  output logic              usb_wr_gnt,
  input  logic              axi_rd_req,
  output logic [DATA_W-1:0] axi_rd_data,
  output logic              axi_rd_toggle,
  output logic              mem_cs,
  output logic              mem_we_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DATA} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_elig;
  logic              rd_elig;
  logic              wr_win;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign mem_wdata = usb_wr_data;
  assign wr_elig   = usb_wr_req & ~full;
  assign rd_elig   = axi_rd_req & ~empty;

`ifdef USB_BUF_ARB_WR_PRIO_EN
  assign wr_win = wr_elig;
`else
  // last_rd=1 means the read side won the previous grant, so a contest goes to write
  logic last_rd;
  assign wr_win = wr_elig & (~rd_elig | last_rd);
`endif

  // Memory strobes are registered alongside the state so they are high exactly in WR/RD
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      axi_rd_toggle <= 1'b0;
      axi_rd_data   <= '0;
      usb_wr_gnt    <= 1'b0;
      mem_cs        <= 1'b0;
      mem_we_b      <= 1'b1;
      mem_addr      <= '0;
`ifndef USB_BUF_ARB_WR_PRIO_EN
      last_rd       <= 1'b1;
`endif
    end else begin
      usb_wr_gnt <= 1'b0;
      mem_cs     <= 1'b0;
      mem_we_b   <= 1'b1;
      mem_addr   <= '0;
      case (state)
        IDLE: begin
          if (wr_win) begin
            state      <= WR;
            usb_wr_gnt <= 1'b1;
            mem_cs     <= 1'b1;
            mem_we_b   <= 1'b0;
            mem_addr   <= wr_ptr;
`ifndef USB_BUF_ARB_WR_PRIO_EN
            last_rd    <= 1'b0;
`endif
          end else if (rd_elig) begin
            state    <= RD;
            mem_cs   <= 1'b1;
            mem_addr <= rd_ptr;
`ifndef USB_BUF_ARB_WR_PRIO_EN
            last_rd  <= 1'b1;
`endif
          end
        end
        WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
          state  <= IDLE;
        end
        RD: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          axi_rd_data   <= mem_rdata;
          axi_rd_toggle <= ~axi_rd_toggle;
          rd_ptr        <= rd_ptr + 1'b1;
          count         <= count - 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_buf_arb.sv
// tb/tb_usb_buf_arb.sv - directed and random bench for usb_buf_arb against a queue model.
module tb_usb_buf_arb;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          Clk, Rst;
  logic          usb_wr_req, usb_wr_gnt, axi_rd_req, axi_rd_toggle;
  logic          mem_cs, mem_we_b, full, empty;
  logic [DW-1:0] usb_wr_data, axi_rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   count;

  usb_buf_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .usb_wr_req(usb_wr_req), .usb_wr_data(usb_wr_data), .usb_wr_gnt(usb_wr_gnt),
    .axi_rd_req(axi_rd_req), .axi_rd_data(axi_rd_data), .axi_rd_toggle(axi_rd_toggle),
    .mem_cs(mem_cs), .mem_we_b(mem_we_b), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count(count), .full(full), .empty(empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // single-port buffer memory: read data appears the cycle after the read cycle
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge Clk) begin
    if (mem_cs && !mem_we_b) tb_mem[mem_addr] <= mem_wdata;
    if (mem_cs && mem_we_b) mem_rdata <= tb_mem[mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // transaction-level model: buffer contents as a queue, op = what the current cycle is doing
  // op: 0 idle/decide, 1 write access, 2 read access, 3 read data return
  logic [DW-1:0] m_q[$];
  int            m_op, m_wr_total, m_rd_total;
  bit            m_last_w;
  logic          m_tog;
  logic [DW-1:0] m_data;
  int            dut_ops[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_op = 0;
    m_wr_total = 0;
    m_rd_total = 0;
    m_last_w = 1'b0;
    m_tog = 1'b0;
    m_data = '0;
  endtask

  task automatic step();
    bit we, re, pick_w;
    @(negedge Clk);
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("toggle", axi_rd_toggle, m_tog);
    chk("rd_data", axi_rd_data, m_data);
    case (m_op)
      1: begin
        chk("wr_cs", mem_cs, 1);
        chk("wr_we_b", mem_we_b, 0);
        chk("wr_gnt", usb_wr_gnt, 1);
        chk("wr_addr", mem_addr, m_wr_total % DEPTH);
        chk("wr_wdata", mem_wdata, usb_wr_data);
      end
      2: begin
        chk("rd_cs", mem_cs, 1);
        chk("rd_we_b", mem_we_b, 1);
        chk("rd_gnt", usb_wr_gnt, 0);
        chk("rd_addr", mem_addr, m_rd_total % DEPTH);
      end
      default: begin
        chk("idle_cs", mem_cs, 0);
        chk("idle_we_b", mem_we_b, 1);
        chk("idle_gnt", usb_wr_gnt, 0);
      end
    endcase
    if (!Rst) begin
      model_reset();
    end else begin
      case (m_op)
        0: begin
          we = usb_wr_req && (m_q.size() < DEPTH);
          re = axi_rd_req && (m_q.size() > 0);
`ifdef USB_BUF_ARB_WR_PRIO_EN
          pick_w = we;
`else
          pick_w = we && (!re || !m_last_w);
`endif
          if (pick_w) begin
            m_op = 1;
            m_last_w = 1'b1;
          end else if (re) begin
            m_op = 2;
            m_last_w = 1'b0;
          end
        end
        1: begin
          m_q.push_back(usb_wr_data);
          m_wr_total++;
          m_op = 0;
        end
        2: m_op = 3;
        default: begin
          m_data = m_q.pop_front();
          m_tog = ~m_tog;
          m_rd_total++;
          m_op = 0;
        end
      endcase
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d, input logic [AW-1:0] ea);
    usb_wr_data = d;
    usb_wr_req = 1'b1;
    step();
    usb_wr_req = 1'b0;
    chk("dw_gnt", usb_wr_gnt, 1);
    chk("dw_addr", mem_addr, ea);
    chk("dw_we_b", mem_we_b, 0);
    step();
  endtask

  task automatic do_read(input logic [DW-1:0] ed, input logic et);
    axi_rd_req = 1'b1;
    step();
    axi_rd_req = 1'b0;
    step();
    step();
    chk("dr_data", axi_rd_data, ed);
    chk("dr_toggle", axi_rd_toggle, et);
  endtask

  initial begin
    int exp_ops[4];
    Rst = 1'b0;
    usb_wr_req = 1'b0;
    axi_rd_req = 1'b0;
    usb_wr_data = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_gnt", usb_wr_gnt, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_we_b", mem_we_b, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_toggle", axi_rd_toggle, 0);
    chk("rst_data", axi_rd_data, 0);
    Rst = 1'b1;
    step();
    chk("post_rst_addr", mem_addr, 0);

    do_write(32'hA1, 2'd0);
    do_write(32'hA2, 2'd1);
    do_write(32'hA3, 2'd2);
    chk("w3_count", count, 3);
    chk("w3_empty", empty, 0);
    do_read(32'hA1, 1'b1);
    do_read(32'hA2, 1'b0);
    do_read(32'hA3, 1'b1);
    chk("r3_count", count, 0);
    chk("r3_empty", empty, 1);

    // count=2 with read granted last, then contest for 10 cycles
    do_write(32'h11, 2'd3);
    do_write(32'h12, 2'd0);
    do_write(32'h13, 2'd1);
    do_read(32'h11, 1'b0);
    chk("c2_count", count, 2);
    dut_ops.delete();
    usb_wr_data = 32'h14;
    usb_wr_req = 1'b1;
    axi_rd_req = 1'b1;
    repeat (10) begin
      step();
      if (mem_cs) dut_ops.push_back(mem_we_b ? 2 : 1);
    end
    usb_wr_req = 1'b0;
    axi_rd_req = 1'b0;
    repeat (4) step();
`ifdef USB_BUF_ARB_WR_PRIO_EN
    exp_ops = '{1, 1, 2, 1};
`else
    exp_ops = '{1, 2, 1, 2};
`endif
    chk("arb_n_ops", dut_ops.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("arb_op%0d", i), (i < dut_ops.size()) ? dut_ops[i] : 0, exp_ops[i]);

    // fill to full from fresh pointers, stall a fifth write, then wrap
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    step();
    do_write(32'hB0, 2'd0);
    do_write(32'hB1, 2'd1);
    do_write(32'hB2, 2'd2);
    do_write(32'hB3, 2'd3);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    usb_wr_data = 32'hB4;
    usb_wr_req = 1'b1;
    repeat (5) begin
      step();
      chk("full_no_gnt", usb_wr_gnt, 0);
    end
    usb_wr_req = 1'b0;
    do_read(32'hB0, 1'b1);
    do_write(32'hB4, 2'd0);
    do_read(32'hB1, 1'b0);
    do_read(32'hB2, 1'b1);
    do_read(32'hB3, 1'b0);
    do_read(32'hB4, 1'b1);

    // read request against empty buffer
    axi_rd_req = 1'b1;
    repeat (10) begin
      step();
      chk("empty_rd_cs", mem_cs, 0);
      chk("empty_rd_tog", axi_rd_toggle, 1);
    end
    axi_rd_req = 1'b0;

    // reset landing on the read-data cycle
    do_write(32'hC0, 2'd1);
    do_write(32'hC1, 2'd2);
    axi_rd_req = 1'b1;
    step();
    axi_rd_req = 1'b0;
    step();
    Rst = 1'b0;
    step();
    chk("abort_count", count, 0);
    chk("abort_toggle", axi_rd_toggle, 0);
    chk("abort_cs", mem_cs, 0);
    Rst = 1'b1;
    repeat (3) step();
    chk("abort_toggle_hold", axi_rd_toggle, 0);

    for (int blk = 0; blk < 12; blk++) begin
      int pw, pr;
      pw = $urandom_range(1, 9);
      pr = $urandom_range(1, 9);
      for (int c = 0; c < 50; c++) begin
        int prev_op;
        prev_op = m_op;
        step();
        if (prev_op == 1 || !usb_wr_req) begin
          usb_wr_req = ($urandom_range(0, 9) < pw);
          usb_wr_data = $urandom;
        end
        axi_rd_req = ($urandom_range(0, 9) < pr);
      end
    end
    usb_wr_req = 1'b0;
    axi_rd_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
